// File: rtl/param_rf_pkg.sv
// Shared types and helpers for the parametrised info register file.
// Holds the address-decode result type and the byte-to-word address offset.
package param_rf_pkg;

  localparam int BYTE_ADDR_LSB = 3;

  typedef enum logic [1:0] {
    DEC_REG,
    DEC_ID,
    DEC_INVALID
  } dec_e;

  // Ceiling log2, never below 1 so it can size an index for a single register.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/param_rf_reg.sv
// One shared software/hardware register, either plain storage or a counter.
// Software writes win over hardware loads and increments in the same cycle.
module param_rf_reg #(
  parameter int              REG_WIDTH   = 16,
  parameter bit              IS_COUNTER  = 1'b0,
  parameter logic [REG_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 sw_we,
  input  logic [REG_WIDTH-1:0] sw_data,
  input  logic [REG_WIDTH-1:0] hw_next,
  input  logic                 hw_wen,
  input  logic                 hw_inc,
  output logic [REG_WIDTH-1:0] q,
  output logic                 written,
  output logic                 wrap
);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      q       <= RESET_VALUE;
      written <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      written <= sw_we;
      wrap    <= 1'b0;
      if (sw_we) begin
        q <= sw_data;
      end else if (IS_COUNTER && hw_inc) begin
        q    <= q + 1'b1;
        wrap <= &q;
      end else if (!IS_COUNTER && hw_wen) begin
        q <= hw_next;
      end
    end
  end

endmodule

// File: rtl/param_info_rf.sv
// Parametrised info register file: NUM_REGS shared registers plus a read-only ID word.
// Every accepted request completes exactly one cycle later; reads return pre-edge values.
module param_info_rf
  import param_rf_pkg::*;
#(
  parameter int                           DATA_WIDTH   = 64,
  parameter int                           REG_WIDTH    = 16,
  parameter int                           NUM_REGS     = 4,
  parameter int                           ADDR_WIDTH   = 3,
  parameter logic [NUM_REGS-1:0]          COUNTER_MASK = 4'b1000,
  parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [REG_WIDTH-1:0]         ID_VALUE     = 16'hBEEF
) (
  input  logic                              clk,
  input  logic                              res_n,
  input  logic [ADDR_WIDTH+BYTE_ADDR_LSB-1:BYTE_ADDR_LSB] address,
  input  logic                              read_en,
  input  logic                              write_en,
  input  logic [DATA_WIDTH-1:0]             write_data,
  output logic [DATA_WIDTH-1:0]             read_data,
  output logic                              access_complete,
  output logic                              invalid_address,
  input  logic [NUM_REGS*REG_WIDTH-1:0]     hw_next,
  input  logic [NUM_REGS-1:0]               hw_wen,
  input  logic [NUM_REGS-1:0]               hw_inc,
  output logic [NUM_REGS*REG_WIDTH-1:0]     q,
  output logic [NUM_REGS-1:0]               written,
  output logic [NUM_REGS-1:0]               wrap
);

  localparam int IDX_W = clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ID_ADDR = ADDR_WIDTH'(NUM_REGS);

  logic [ADDR_WIDTH-1:0] word_addr;
  logic [IDX_W-1:0]      reg_idx;
  dec_e                  dec;
  logic [REG_WIDTH-1:0]  q_arr [NUM_REGS];
  logic [REG_WIDTH-1:0]  rd_word;
  logic                  req;

  assign word_addr = address;
  assign reg_idx   = word_addr[IDX_W-1:0];
  assign req       = read_en | write_en;

  always_comb begin
    dec = DEC_INVALID;
    if (word_addr < ID_ADDR) dec = DEC_REG;
    else if (word_addr == ID_ADDR) dec = DEC_ID;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic sw_we;
      assign sw_we = write_en && (dec == DEC_REG) && (word_addr == ADDR_WIDTH'(gi));

      param_rf_reg #(
        .REG_WIDTH  (REG_WIDTH),
        .IS_COUNTER (COUNTER_MASK[gi]),
        .RESET_VALUE(RESET_VALUE[gi*REG_WIDTH +: REG_WIDTH])
      ) u_reg (
        .clk    (clk),
        .res_n  (res_n),
        .sw_we  (sw_we),
        .sw_data(write_data[REG_WIDTH-1:0]),
        .hw_next(hw_next[gi*REG_WIDTH +: REG_WIDTH]),
        .hw_wen (hw_wen[gi]),
        .hw_inc (hw_inc[gi]),
        .q      (q[gi*REG_WIDTH +: REG_WIDTH]),
        .written(written[gi]),
        .wrap   (wrap[gi])
      );

      assign q_arr[gi] = q[gi*REG_WIDTH +: REG_WIDTH];
    end

    if (DATA_WIDTH > REG_WIDTH) begin : g_unused_data
      logic unused_wdata;
      assign unused_wdata = ^write_data[DATA_WIDTH-1:REG_WIDTH];
    end
  endgenerate

  // reg_idx may point past the last register only when dec is not DEC_REG.
  always_comb begin
    rd_word = '0;
    case (dec)
      DEC_REG: rd_word = q_arr[reg_idx];
      DEC_ID:  rd_word = ID_VALUE;
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      read_data       <= '0;
      access_complete <= 1'b0;
      invalid_address <= 1'b0;
    end else begin
      access_complete <= req;
      invalid_address <= req && (dec == DEC_INVALID);
      // A simultaneous write suppresses the read, leaving read_data untouched.
      if (read_en && !write_en) read_data <= DATA_WIDTH'(rd_word);
    end
  end

endmodule

// File: tb/tb_param_info_rf.sv
// Directed self-checking bench for param_info_rf with default parameters.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_param_info_rf;

  logic        clk;
  logic        res_n;
  logic [5:3]  address;
  logic        read_en;
  logic        write_en;
  logic [63:0] write_data;
  logic [63:0] read_data;
  logic        access_complete;
  logic        invalid_address;
  logic [63:0] hw_next;
  logic [3:0]  hw_wen;
  logic [3:0]  hw_inc;
  logic [63:0] q;
  logic [3:0]  written;
  logic [3:0]  wrap;

  int checks = 0;
  int errors = 0;

  param_info_rf dut (
    .clk            (clk),
    .res_n          (res_n),
    .address        (address),
    .read_en        (read_en),
    .write_en       (write_en),
    .write_data     (write_data),
    .read_data      (read_data),
    .access_complete(access_complete),
    .invalid_address(invalid_address),
    .hw_next        (hw_next),
    .hw_wen         (hw_wen),
    .hw_inc         (hw_inc),
    .q              (q),
    .written        (written),
    .wrap           (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    read_en  = 1'b0;
    write_en = 1'b0;
    hw_wen   = '0;
    hw_inc   = '0;
  endtask

  // Apply the current inputs for one rising edge, then return them to idle.
  task automatic cycle();
    @(negedge clk);
    idle();
  endtask

  initial begin
    res_n = 1'b0; address = '0; write_data = '0; hw_next = '0;
    idle();
    @(negedge clk);
    @(negedge clk);
    res_n = 1'b1;
    chk("rst_q", q, 64'h0);
    chk("rst_rdata", read_data, 64'h0);
    chk("rst_ac", 64'(access_complete), 64'h0);
    chk("rst_inv", 64'(invalid_address), 64'h0);
    chk("rst_written", 64'(written), 64'h0);
    chk("rst_wrap", 64'(wrap), 64'h0);

    // ID word
    address = 3'd4; read_en = 1'b1; cycle();
    chk("id_rdata", read_data, 64'hBEEF);
    chk("id_ac", 64'(access_complete), 64'h1);
    chk("id_inv", 64'(invalid_address), 64'h0);
    @(negedge clk);
    chk("id_ac_drop", 64'(access_complete), 64'h0);

    // Software write then read of word 1
    address = 3'd1; write_en = 1'b1; write_data = 64'hDEAD_0000_0000_1234; cycle();
    chk("wr1_written", 64'(written), 64'h2);
    chk("wr1_q", q, 64'h0000_0000_1234_0000);
    chk("wr1_ac", 64'(access_complete), 64'h1);
    @(negedge clk);
    chk("wr1_written_drop", 64'(written), 64'h0);
    chk("wr1_ac_drop", 64'(access_complete), 64'h0);
    address = 3'd1; read_en = 1'b1; cycle();
    chk("rd1_rdata", read_data, 64'h1234);
    chk("rd1_ac", 64'(access_complete), 64'h1);
    @(negedge clk);
    chk("rd1_ac_drop", 64'(access_complete), 64'h0);
    chk("rd1_rdata_hold", read_data, 64'h1234);

    // Invalid addresses
    address = 3'd6; read_en = 1'b1; cycle();
    chk("inv_rd_ac", 64'(access_complete), 64'h1);
    chk("inv_rd_inv", 64'(invalid_address), 64'h1);
    chk("inv_rd_rdata", read_data, 64'h0);
    address = 3'd7; write_en = 1'b1; write_data = 64'hFFFF; cycle();
    chk("inv_wr_inv", 64'(invalid_address), 64'h1);
    chk("inv_wr_q", q, 64'h0000_0000_1234_0000);
    chk("inv_wr_written", 64'(written), 64'h0);

    // Write to ID completes valid and changes nothing
    address = 3'd4; write_en = 1'b1; write_data = 64'h5555; cycle();
    chk("idwr_ac", 64'(access_complete), 64'h1);
    chk("idwr_inv", 64'(invalid_address), 64'h0);
    chk("idwr_q", q, 64'h0000_0000_1234_0000);
    address = 3'd4; read_en = 1'b1; cycle();
    chk("idwr_rdata", read_data, 64'hBEEF);

    // Counter wrap on word 3
    address = 3'd3; write_en = 1'b1; write_data = 64'hFFFE; cycle();
    chk("cnt_wr_q", 64'(q[63:48]), 64'hFFFE);
    chk("cnt_wr_written", 64'(written), 64'h8);
    chk("cnt_wr_wrap", 64'(wrap), 64'h0);
    hw_inc = 4'b1000; cycle();
    chk("cnt_inc1_q", 64'(q[63:48]), 64'hFFFF);
    chk("cnt_inc1_wrap", 64'(wrap), 64'h0);
    hw_inc = 4'b1000; cycle();
    chk("cnt_inc2_q", 64'(q[63:48]), 64'h0000);
    chk("cnt_inc2_wrap", 64'(wrap), 64'h8);
    @(negedge clk);
    chk("cnt_wrap_drop", 64'(wrap), 64'h0);
    hw_wen = 4'b1000; hw_next = 64'h1111_0000_0000_0000; cycle();
    chk("cnt_hwwen_ignored", 64'(q[63:48]), 64'h0000);

    // Software write beats hw load; simultaneous read is dropped
    address = 3'd0; write_en = 1'b1; read_en = 1'b1; write_data = 64'h00AA;
    hw_wen = 4'b0001; hw_next = 64'h0055;
    cycle();
    chk("col_q0", 64'(q[15:0]), 64'h00AA);
    chk("col_written", 64'(written), 64'h1);
    chk("col_ac", 64'(access_complete), 64'h1);
    chk("col_rdata_hold", read_data, 64'hBEEF);
    @(negedge clk);
    chk("col_ac_single", 64'(access_complete), 64'h0);

    // Hardware load alone, and increment ignored on a plain register
    hw_wen = 4'b0001; hw_next = 64'h0055; cycle();
    chk("hwwen_q0", 64'(q[15:0]), 64'h0055);
    chk("hwwen_written", 64'(written), 64'h0);
    hw_inc = 4'b0001; cycle();
    chk("inc_plain_ignored", 64'(q[15:0]), 64'h0055);

    // Software write beats increment on the counter, no wrap
    address = 3'd3; write_en = 1'b1; write_data = 64'h0007; hw_inc = 4'b1000; cycle();
    chk("cntcol_q", 64'(q[63:48]), 64'h0007);
    chk("cntcol_wrap", 64'(wrap), 64'h0);

    // Read sees the pre-edge value during a hw update
    address = 3'd0; read_en = 1'b1; hw_wen = 4'b0001; hw_next = 64'h0066; cycle();
    chk("preedge_rdata", read_data, 64'h0055);
    chk("preedge_q0", 64'(q[15:0]), 64'h0066);

    // Reset during an access aborts it
    address = 3'd1; read_en = 1'b1;
    #2 res_n = 1'b0;
    cycle();
    @(negedge clk);
    res_n = 1'b1;
    chk("midrst_ac", 64'(access_complete), 64'h0);
    chk("midrst_q", q, 64'h0);
    chk("midrst_rdata", read_data, 64'h0);
    @(negedge clk);
    chk("midrst_ac_after", 64'(access_complete), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_info_rf.md
Name: param_info_rf

Overview:
- Parametrised successor to the generated fixed-map info register file.
- Provides NUM_REGS software/hardware-shared registers of REG_WIDTH bits, selectable per register as plain storage or as hardware-incremented counters.
- Includes a read-only ID word and invalid-address detection.
- Sits between the host register bus (address/read_en/write_en/access_complete) and block logic.

Parameters:
- DATA_WIDTH, 64, bus data width; write_data and read_data width.
- REG_WIDTH, 16, width of each register; must be <= DATA_WIDTH.
- NUM_REGS, 4, number of registers; must be <= 2**ADDR_WIDTH - 1.
- ADDR_WIDTH, 3, word-address bits; the port carries byte address bits [ADDR_WIDTH+2:3].
- COUNTER_MASK, 4'b1000, NUM_REGS bits; bit i=1 makes register i a counter.
- RESET_VALUE, 0, NUM_REGS*REG_WIDTH packed reset values; register i occupies slice [i*REG_WIDTH +: REG_WIDTH].
- ID_VALUE, 16'hBEEF, REG_WIDTH constant returned at word NUM_REGS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- res_n  input  1  asynchronous active-low reset.
- address  input  ADDR_WIDTH ([ADDR_WIDTH+2:3])  word address.
- read_en  input  1  read request, one-cycle qualifier.
- write_en  input  1  write request, one-cycle qualifier.
- write_data  input  DATA_WIDTH  software write data; only the low REG_WIDTH bits are used.
- read_data  output  DATA_WIDTH  registered read result, zero-extended.
- access_complete  output  1  one-cycle pulse, one cycle after each accepted request.
- invalid_address  output  1  qualifies access_complete; set when the address is unmapped.
- hw_next  input  NUM_REGS*REG_WIDTH  hardware load values.
- hw_wen  input  NUM_REGS  hardware load enables (ignored for counter registers).
- hw_inc  input  NUM_REGS  increment strobes (ignored for non-counter registers).
- q  output  NUM_REGS*REG_WIDTH  current register values.
- written  output  NUM_REGS  one-cycle pulse after a software write to register i.
- wrap  output  NUM_REGS  one-cycle pulse when counter i wraps from all-ones to 0.

Behaviour:
- Reset (asynchronous, res_n=0):
  - q = RESET_VALUE.
  - read_data = 0.
  - access_complete, invalid_address, written, wrap = 0.
  - Reset mid-access aborts the access: no access_complete is produced.
- Address map:
  - Words 0..NUM_REGS-1 are registers.
  - Word NUM_REGS is ID (read-only; writes are ignored but complete valid).
  - Words above NUM_REGS are invalid.
- Request acceptance: a request is accepted in any cycle where read_en or write_en is high; there is no busy state and back-to-back requests are accepted.
- Latency: exactly one cycle. In the cycle after acceptance, access_complete=1 and invalid_address reflects the decode; otherwise both are 0.
- Read:
  - read_data <= zero-extended q[i] or ID_VALUE.
  - For an invalid address, read_data <= 0.
  - read_data holds its value between reads.
- Write: register i <= write_data[REG_WIDTH-1:0]; written[i] pulses in the following cycle.
- read_en and write_en both high: the write is performed, the read is not performed, read_data holds, and exactly one access_complete pulse follows.
- Register update priority, highest first:
  1. Software write.
  2. hw_wen (non-counter) or hw_inc (counter).
  3. Hold.
- Dropped events: a software write and hw_inc in the same cycle on a counter loads the software value and drops the increment; a software write and hw_wen in the same cycle likewise drops the hardware load.
- Counters:
  - Increment by 1 modulo 2**REG_WIDTH.
  - On all-ones -> 0 via hw_inc, wrap[i] pulses the next cycle.
  - A software write never raises wrap.
- q reflects register contents with no extra delay: an update at edge N is visible on q after edge N.
- Reads observe the pre-edge value: a read in the same cycle as a hw update returns the pre-update value.

Decomposition:
- Shared package param_rf_pkg:
  - function clog2;
  - address-decode result enum (DEC_REG, DEC_ID, DEC_INVALID);
  - localparam BYTE_ADDR_LSB = 3.
- One natural sub-module, param_rf_reg: a single REG_WIDTH register with the IS_COUNTER parameter, priority logic and the written/wrap pulses. It is instantiated NUM_REGS times in a generate loop.
- The top level holds the decode, the read mux and the access_complete/invalid_address flops.

Test Plan:
- Reset check: hold res_n=0 for 2 cycles, release -> q=0, read_data=0, access_complete=0; read word 4 -> read_data=64'hBEEF one cycle later with invalid_address=0.
- Software write/read: write 16'h1234 to word 1 -> written=4'b0010 for exactly one cycle, q[31:16]=16'h1234; read word 1 -> read_data=64'h1234 and access_complete pulses once.
- Invalid address: read word 6 -> access_complete=1, invalid_address=1, read_data=0; write word 7 -> no q change, no written pulse.
- Counter wrap: write 16'hFFFE to word 3, then pulse hw_inc[3] twice -> q[63:48] goes FFFF then 0000, wrap[3] pulses once after the second increment.
- Collision: in the same cycle, write 16'h00AA to word 0 and assert hw_wen[0] with hw_next=16'h0055 -> q[15:0]=16'h00AA and written[0]=1. Also assert read_en with write_en -> read_data unchanged and a single access_complete pulse.
- Reset mid-operation: assert read_en, drop res_n in the same cycle -> no access_complete after reset release, and q returns to RESET_VALUE.
